// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and latency defaults for the ALU op sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 64;
    localparam int DEF_ADD_LAT = 1;
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 16;

    // Largest of the three unit latencies; sizes the shared down-counter.
    function automatic int max_lat(input int add_lat, input int mul_lat, input int div_lat);
        int m;
        m = add_lat;
        if (mul_lat > m) m = mul_lat;
        if (div_lat > m) m = div_lat;
        return m;
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// rtl/alu_lat_counter.sv - loadable down-counter with zero flag for unit latency
module alu_lat_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    logic [CW-1:0] count_q;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one ALU op at a time through the shared result mux
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic [1:0]       mux_select,
    input  logic [WIDTH-1:0] mux_output,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_div_zero,
    output logic             busy
);

    localparam int MAX_LAT = max_lat(ADD_LAT, MUL_LAT, DIV_LAT);
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t             state_q;
    logic [WIDTH-1:0]   unit_a_q;
    logic [WIDTH-1:0]   unit_b_q;
    logic [1:0]         mux_select_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_div_zero_q;

    logic               accept;
    logic               div_by_zero;
    logic               cnt_load;
    logic               cnt_dec;
    logic [CW-1:0]      cnt_load_d;
    logic [CW-1:0]      cnt_value;
    logic               cnt_zero;

    assign accept      = (state_q == S_IDLE) && req_valid;
    assign div_by_zero = (op_t'(req_op) == OP_DIV) && (req_b == '0);
    assign cnt_load    = accept && !div_by_zero;
    assign cnt_dec     = (state_q == S_EXEC);

    // Counter preload is the chosen unit's latency minus one, so zero is reached on the capture edge.
    always_comb begin
        cnt_load_d = '0;
        case (op_t'(req_op))
            OP_ADD, OP_SUB: cnt_load_d = CW'(ADD_LAT - 1);
            OP_MUL:         cnt_load_d = CW'(MUL_LAT - 1);
            OP_DIV:         cnt_load_d = CW'(DIV_LAT - 1);
            default:        cnt_load_d = '0;
        endcase
    end

    alu_lat_counter #(
        .CW (CW)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_d),
        .dec_i      (cnt_dec),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    // Sequencer FSM: accept in IDLE, wait out the unit latency in EXEC, hold the result in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            unit_a_q       <= '0;
            unit_b_q       <= '0;
            mux_select_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        mux_select_q <= req_op;
                        unit_a_q     <= req_a;
                        unit_b_q     <= req_b;
                        if (div_by_zero) begin
                            // No unit result to wait for; answer immediately with the saturated quotient.
                            rsp_data_q     <= '1;
                            rsp_div_zero_q <= 1'b1;
                            rsp_valid_q    <= 1'b1;
                            state_q        <= S_RESP;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_zero) begin
                        rsp_data_q     <= mux_output;
                        rsp_div_zero_q <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        state_q        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign unit_a       = unit_a_q;
    assign unit_b       = unit_b_q;
    assign mux_select   = mux_select_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_div_zero = rsp_div_zero_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int W       = 64;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [W-1:0]  unit_a;
    logic [W-1:0]  unit_b;
    logic [1:0]    mux_select;
    logic [W-1:0]  mux_output;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_div_zero;
    logic          busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    alu_op_sequencer #(
        .WIDTH   (W),
        .ADD_LAT (1),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .unit_a       (unit_a),
        .unit_b       (unit_b),
        .mux_select   (mux_select),
        .mux_output   (mux_output),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_div_zero (rsp_div_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unit models: add/sub combinational (latency 1), mult/div delayed by LAT-1 register stages.
    logic [W-1:0] add_c, sub_c, mul_c, div_c;
    logic [W-1:0] mul_hist [16];
    logic [W-1:0] div_hist [16];

    assign add_c = unit_a + unit_b;
    assign sub_c = unit_a - unit_b;
    assign mul_c = unit_a * unit_b;
    assign div_c = (unit_b == '0) ? '1 : unit_a / unit_b;

    always @(posedge clk) begin
        mul_hist[0] <= mul_c;
        div_hist[0] <= div_c;
        for (int i = 1; i < 16; i++) begin
            mul_hist[i] <= mul_hist[i-1];
            div_hist[i] <= div_hist[i-1];
        end
    end

    always_comb begin
        mux_output = '0;
        case (mux_select)
            2'd0:    mux_output = add_c;
            2'd1:    mux_output = sub_c;
            2'd2:    mux_output = mul_hist[MUL_LAT-2];
            default: mux_output = div_hist[DIV_LAT-2];
        endcase
    end

    // Present a request and hold it until accepted; returns the accept cycle (-1 if never accepted).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int acc_cyc);
        acc_cyc = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin
                @(posedge clk);
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        #1 req_valid = 1'b0;
    endtask

    // Count cycles from the accept edge (counted as 1) until rsp_valid is seen; -1 on timeout.
    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b want 1", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); else passed++;
        total++; if (rsp_data !== '0) $display("FAIL reset_rsp_data got %0h want 0", rsp_data); else passed++;
        total++; if (rsp_div_zero !== 1'b0) $display("FAIL reset_div_zero got %0b want 0", rsp_div_zero); else passed++;
        total++; if (mux_select !== 2'd0) $display("FAIL reset_mux_select got %0d want 0", mux_select); else passed++;
        total++; if (unit_a !== '0 || unit_b !== '0) $display("FAIL reset_units got %0h/%0h want 0/0", unit_a, unit_b); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    endtask

    task automatic test_add();
        int acc, n;
        issue(2'd0, 64'd10, 64'd30, acc);
        total++; if (acc < 0) $display("FAIL add_accept got none want accept"); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("FAIL add_busy got busy=%0b ready=%0b want 1/0", busy, req_ready); else passed++;
        total++; if (mux_select !== 2'd0) $display("FAIL add_mux_select got %0d want 0", mux_select); else passed++;
        n = 1;
        if (!rsp_valid) begin
            wait_rsp(n);
            if (n > 0) n = n + 1;
        end
        total++; if (n !== 2) $display("FAIL add_latency got %0d want 2", n); else passed++;
        total++; if (rsp_data !== 64'd40) $display("FAIL add_data got %0d want 40", rsp_data); else passed++;
        total++; if (rsp_div_zero !== 1'b0) $display("FAIL add_div_zero got %0b want 0", rsp_div_zero); else passed++;
        take_rsp();
    endtask

    task automatic test_mult();
        int acc, n;
        issue(2'd2, 64'd10, 64'd50, acc);
        wait_rsp(n);
        total++; if (n !== MUL_LAT + 1) $display("FAIL mult_latency got %0d want %0d", n, MUL_LAT + 1); else passed++;
        total++; if (rsp_data !== 64'd500) $display("FAIL mult_data got %0d want 500", rsp_data); else passed++;
        total++; if (mux_select !== 2'd2) $display("FAIL mult_mux_select got %0d want 2", mux_select); else passed++;
        take_rsp();
    endtask

    task automatic test_div_zero();
        int acc, n;
        issue(2'd3, 64'd70, 64'd0, acc);
        wait_rsp(n);
        total++; if (n !== 1) $display("FAIL divz_latency got %0d want 1", n); else passed++;
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL divz_data got %0h want ffffffffffffffff", rsp_data); else passed++;
        total++; if (rsp_div_zero !== 1'b1) $display("FAIL divz_flag got %0b want 1", rsp_div_zero); else passed++;
        total++; if (mux_select !== 2'd3) $display("FAIL divz_mux_select got %0d want 3", mux_select); else passed++;
        take_rsp();
    endtask

    task automatic test_backpressure();
        int acc, n;
        issue(2'd1, 64'd70, 64'd30, acc);
        wait_rsp(n);
        total++; if (n !== 2) $display("FAIL bp_latency got %0d want 2", n); else passed++;
        // Offer a competing request while the response is stalled.
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_a     = 64'd3;
        req_b     = 64'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'd40 || req_ready !== 1'b0 || mux_select !== 2'd1)
                $display("FAIL bp_hold cycle %0d got valid=%0b data=%0d ready=%0b sel=%0d want 1/40/0/1",
                         i, rsp_valid, rsp_data, req_ready, mux_select);
            else passed++;
        end
        req_valid = 1'b0;
        take_rsp();
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bp_release got ready=%0b valid=%0b want 1/0", req_ready, rsp_valid); else passed++;
        total++; if (mux_select !== 2'd1 || unit_a !== 64'd70 || unit_b !== 64'd30)
            $display("FAIL bp_idle_hold got sel=%0d a=%0d b=%0d want 1/70/30", mux_select, unit_a, unit_b);
        else passed++;
    endtask

    task automatic test_reset_mid_div();
        int acc, seen;
        issue(2'd3, 64'd700, 64'd7, acc);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_mid_state got ready=%0b busy=%0b want 1/0", req_ready, busy); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_mid_valid got %0b want 0", rsp_valid); else passed++;
        total++; if (mux_select !== 2'd0) $display("FAIL rst_mid_select got %0d want 0", mux_select); else passed++;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        total++; if (seen !== 0) $display("FAIL rst_mid_no_rsp got %0d responses want 0", seen); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]   ops  [3];
        logic [W-1:0] as   [3];
        logic [W-1:0] bs   [3];
        logic [W-1:0] exps [3];
        int           lats [3];
        int acc, n, rsp_cyc;
        ops[0] = 2'd0; as[0] = 64'd5;   bs[0] = 64'd9; exps[0] = 64'd14;  lats[0] = 2;
        ops[1] = 2'd2; as[1] = 64'd6;   bs[1] = 64'd7; exps[1] = 64'd42;  lats[1] = MUL_LAT + 1;
        ops[2] = 2'd3; as[2] = 64'd100; bs[2] = 64'd7; exps[2] = 64'd14;  lats[2] = DIV_LAT + 1;
        rsp_ready = 1'b1;
        rsp_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            issue(ops[k], as[k], bs[k], acc);
            total++; if (acc <= rsp_cyc) $display("FAIL b2b_accept_order op %0d accept %0d rsp %0d", k, acc, rsp_cyc); else passed++;
            wait_rsp(n);
            rsp_cyc = cyc;
            total++; if (n !== lats[k]) $display("FAIL b2b_latency op %0d got %0d want %0d", k, n, lats[k]); else passed++;
            total++; if (rsp_data !== exps[k]) $display("FAIL b2b_data op %0d got %0d want %0d", k, rsp_data, exps[k]); else passed++;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_drain got valid=%0b ready=%0b want 0/1", rsp_valid, req_ready); else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_mult();
        test_div_zero();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
